// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file request server: state encoding,
// default sizing and the hardwired zero-register address.
package regfile_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_storage_array.sv
// 2**ADDR_W x WIDTH register storage: one synchronous write port and two
// combinational read ports, with register 0 hardwired to zero.
module regfile_storage_array
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [WIDTH-1:0]  rdata1_o,
    output logic [WIDTH-1:0]  rdata2_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

    // No reset here: the owner zeroes every entry with an init sweep.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != ZERO))
            mem_q[waddr_i] <= wdata_i;
    end

    assign rdata1_o = (raddr1_i == ZERO) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == ZERO) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/regfile_req_server.sv
// Valid/ready command responder for the register file: zeroes storage after
// reset, then serves one write or read-pair command at a time.
module regfile_req_server
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr1,
    input  logic [ADDR_W-1:0] ReqAddr2,
    input  logic [WIDTH-1:0]  ReqWriteData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [WIDTH-1:0]  RspData1,
    output logic [WIDTH-1:0]  RspData2,
    output logic              Busy
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_d1_q, rsp_d1_d;
    logic [WIDTH-1:0]  rsp_d2_q, rsp_d2_d;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata1, rdata2;
    logic              accept;

    regfile_storage_array #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (Clk),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .raddr1_i (ReqAddr1),
        .raddr2_i (ReqAddr2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = ST_IDLE;
            end
            ST_IDLE: if (ReqValid) state_d = ST_RESP;
            ST_RESP: if (RspReady) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // Write port mux: zero sweep during INIT, request fields during IDLE.
    always_comb begin
        ReqReady = 1'b0;
        Busy     = 1'b0;
        we       = 1'b0;
        waddr    = cnt_q;
        wdata    = '0;
        case (state_q)
            ST_INIT: begin
                Busy = 1'b1;
                we   = 1'b1;
            end
            ST_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid && ReqWrite) begin
                    we    = 1'b1;
                    waddr = ReqAddr1;
                    wdata = ReqWriteData;
                end
            end
            default: ;
        endcase
    end

    assign accept = ReqValid && ReqReady;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_d1_d    = rsp_d1_q;
        rsp_d2_d    = rsp_d2_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            if (ReqWrite) begin
                rsp_d1_d = (ReqAddr1 == ZERO) ? '0 : ReqWriteData;
                rsp_d2_d = '0;
            end else begin
                rsp_d1_d = rdata1;
                rsp_d2_d = rdata2;
            end
        end else if (rsp_valid_q && RspReady) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_d1_q    <= '0;
            rsp_d2_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_d1_q    <= rsp_d1_d;
            rsp_d2_q    <= rsp_d2_d;
        end
    end

    assign RspValid = rsp_valid_q;
    assign RspData1 = rsp_d1_q;
    assign RspData2 = rsp_d2_q;

endmodule

// File: tb/tb_regfile_req_server.sv
// Directed bench for regfile_req_server: init timing, read/write responses,
// zero register, backpressure and mid-operation reset.
module tb_regfile_req_server;

    localparam int W = 32;
    localparam int A = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [A-1:0] req_a1 = '0;
    logic [A-1:0] req_a2 = '0;
    logic [W-1:0] req_wd = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_d1, rsp_d2;
    logic         busy;

    int checks = 0;
    int failures = 0;

    regfile_req_server #(.WIDTH(W), .ADDR_W(A)) dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .ReqValid     (req_valid),
        .ReqReady     (req_ready),
        .ReqWrite     (req_write),
        .ReqAddr1     (req_a1),
        .ReqAddr2     (req_a2),
        .ReqWriteData (req_wd),
        .RspValid     (rsp_valid),
        .RspReady     (rsp_ready),
        .RspData1     (rsp_d1),
        .RspData2     (rsp_d2),
        .Busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Count edges from reset release to the first ReqReady; flags any response.
    task automatic count_init(input string tag);
        int n = 0;
        bit early = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) early = 1;
            if (!req_ready && !busy) early = 1;
        end
        chk({tag, "_cycles"}, 64'(n), 64'd32);
        chk({tag, "_quiet"}, 64'(early), 64'd0);
        chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
    endtask

    task automatic issue(input string tag, input logic w, input logic [A-1:0] a1,
                         input logic [A-1:0] a2, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        req_write = w; req_a1 = a1; req_a2 = a2; req_wd = d; req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_vld_lo"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rdy_hi"}, 64'(req_ready), 64'd1);
    endtask

    task automatic txn(input string tag, input logic w, input logic [A-1:0] a1,
                       input logic [A-1:0] a2, input logic [W-1:0] d,
                       input logic [W-1:0] e1, input logic [W-1:0] e2);
        issue(tag, w, a1, a2, d);
        chk({tag, "_d1"}, 64'(rsp_d1), 64'(e1));
        chk({tag, "_d2"}, 64'(rsp_d2), 64'(e2));
        finish_rsp(tag);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_vld", 64'(rsp_valid), 64'd0);
        chk("rst_rdy", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_d1", 64'(rsp_d1), 64'd0);
        chk("rst_d2", 64'(rsp_d2), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        count_init("init1");

        txn("rd_1_31", 1'b0, 5'd1, 5'd31, 32'd0, 32'd0, 32'd0);
        txn("rd_17_2", 1'b0, 5'd17, 5'd2, 32'd0, 32'd0, 32'd0);

        txn("wr_r2_42", 1'b1, 5'd2, 5'd7, 32'd42, 32'd42, 32'd0);
        txn("rd_2_2a", 1'b0, 5'd2, 5'd2, 32'd0, 32'd42, 32'd42);
        txn("wr_r2_15", 1'b1, 5'd2, 5'd0, 32'd15, 32'd15, 32'd0);
        txn("rd_2_2b", 1'b0, 5'd2, 5'd2, 32'd0, 32'd15, 32'd15);
        txn("rd_2_1", 1'b0, 5'd2, 5'd1, 32'd0, 32'd15, 32'd0);

        txn("wr_r0", 1'b1, 5'd0, 5'd0, 32'd15, 32'd0, 32'd0);
        txn("rd_0_0", 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        txn("wr_r31", 1'b1, 5'd31, 5'd0, 32'hdeadbeef, 32'hdeadbeef, 32'd0);
        txn("rd_31_2", 1'b0, 5'd31, 5'd2, 32'd0, 32'hdeadbeef, 32'd15);

        // backpressure: hold RspReady low while another request waits
        issue("bp", 1'b0, 5'd2, 5'd2, 32'd0);
        req_write = 1'b0; req_a1 = 5'd31; req_a2 = 5'd31; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 64'(rsp_valid), 64'd1);
            chk("bp_d1", 64'(rsp_d1), 64'd15);
            chk("bp_d2", 64'(rsp_d2), 64'd15);
            chk("bp_rdy", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_hs_vld", 64'(rsp_valid), 64'd0);
        chk("bp_hs_rdy", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_vld", 64'(rsp_valid), 64'd1);
        chk("bp_next_d1", 64'(rsp_d1), 64'hdeadbeef);
        finish_rsp("bp_next");

        // reset while a response is pending
        issue("wr_r5", 1'b1, 5'd5, 5'd0, 32'd7);
        chk("wr_r5_d1", 64'(rsp_d1), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rdy", 64'(req_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        count_init("init2");
        txn("rd_5_5", 1'b0, 5'd5, 5'd5, 32'd0, 32'd0, 32'd0);
        txn("rd_2_post", 1'b0, 5'd2, 5'd31, 32'd0, 32'd0, 32'd0);

        // request held through the whole init sweep
        @(negedge clk);
        rst_n = 1'b0;
        req_write = 1'b1; req_a1 = 5'd3; req_a2 = 5'd0; req_wd = 32'd9; req_valid = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        count_init("init3");
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("held_vld", 64'(rsp_valid), 64'd1);
        chk("held_d1", 64'(rsp_d1), 64'd9);
        chk("held_d2", 64'(rsp_d2), 64'd0);
        finish_rsp("held");
        txn("rd_3_3", 1'b0, 5'd3, 5'd3, 32'd0, 32'd9, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_req_server.md
# regfile_req_server

Handshaked responder for the 32-entry register file. A requester, such as a test sequencer or a pipeline front end, issues read-pair or write commands over a valid/ready request channel. The block performs each command against internal storage and returns a registered response over a valid/ready response channel. After every reset the block zeroes all storage by itself before it accepts any request.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- ADDR_W, 5, address width; depth = 2**ADDR_W

Ports:
- Clk  in  1  clock, positive-edge
- Reset_n  in  1  reset, asynchronous, active-low
- ReqValid  in  1  request present
- ReqReady  out  1  block accepts request this cycle
- ReqWrite  in  1  1 = write, 0 = read pair
- ReqAddr1  in  ADDR_W  write address (write) / first read address (read)
- ReqAddr2  in  ADDR_W  second read address; ignored on writes
- ReqWriteData  in  WIDTH  data for writes
- RspValid  out  1  response present
- RspReady  in  1  requester takes response
- RspData1  out  WIDTH  response word 1
- RspData2  out  WIDTH  response word 2
- Busy  out  1  init sweep in progress

## Operation
- States: INIT, IDLE, RESP.
- Reset values: state=INIT, init counter=0, ReqReady=0, RspValid=0, RspData1=0, RspData2=0, Busy=1.
- INIT:
  - Each cycle writes 0 to reg[counter], then counter+1.
  - After the write of entry 2**ADDR_W-1, go to IDLE and drop Busy.
  - Requests are ignored during INIT; ReqReady=0.
- IDLE:
  - ReqReady=1.
  - On ReqValid&&ReqReady at edge E, capture the request and go to RESP.
  - Write: the storage is updated at E, except when ReqAddr1=0. At E, RspData1 is loaded with ReqWriteData, or with 0 if ReqAddr1=0. RspData2 is loaded with 0.
  - Read: at E, RspData1 is loaded with reg[ReqAddr1] and RspData2 with reg[ReqAddr2]. Address 0 always reads 0. Both ports may name the same address.
- RESP:
  - RspValid=1 and ReqReady=0.
  - RspData1/RspData2 are held stable until RspValid&&RspReady. At that edge go to IDLE and clear RspValid.
- RspValid must never drop without a handshake, except on reset.
- Register 0 is hardwired to 0: writes to it are discarded, but the write is still acknowledged.
- Ordering: a read accepted after a write's response completes always returns the new value. Commands never overlap, so no bypass is needed.
- Reset mid-operation: RspValid and ReqReady fall immediately. Any pending response is lost, storage is re-zeroed through INIT, and the requester must reissue.

## Timing
- Init: 2**ADDR_W cycles from reset release to the first ReqReady=1. The default is 32 cycles.
- Response latency: RspValid rises on the edge that accepts the request, so the response is visible one cycle after acceptance.
- Throughput: with RspReady held high, one request completes every 2 cycles (accept, then respond). ReqReady is high in the cycle after the response handshake.
- ReqReady and Busy are decoded combinationally from the state register only, never from any input. RspValid and RspData are registered.

## Structure
- Shared package regfile_pkg:
  - state encoding constants (INIT, IDLE, RESP)
  - default WIDTH and ADDR_W
  - the zero-register address constant
- Sub-module regfile_storage_array:
  - 2**ADDR_W x WIDTH array
  - one synchronous write port (enable, address, data); writes to address 0 are suppressed inside
  - two combinational read ports; address 0 returns 0
  - the FSM, init counter and response registers live in regfile_req_server
- The init sweep drives the array write port through a mux: counter/zero during INIT, request fields during IDLE.

## Test plan
- Reset, then count cycles to the first ReqReady: exactly 32 cycles. Read pairs (1,31) and (17,2) then return 0/0.
- Write 42 to r2, then read (2,2): write response 42/0, read response 42/42. Then write 15 to r2 and read (2,2): 15/15.
- Write 15 to r0: write response 0/0. Read (0,0): 0/0.
- Hold RspReady low for 5 cycles after a read of r2=15: RspValid stays 1, data stays 15/15, and ReqReady stays 0 while ReqValid is held high. The next request is accepted only in the cycle after RspReady rises.
- Pulse Reset_n low while in RESP after writing 7 to r5: RspValid falls immediately and Busy=1 for 32 cycles. A subsequent read of (5,5) returns 0/0.
- Assert ReqValid with ReqWrite=1, addr 3, data 9 throughout INIT: there is no acceptance before INIT ends, and a read of (3,3) after the first accepted write returns 9/9.
